// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding and parity modes.
package uart_pkg;

  // Serializer states. Encodings 5..7 are unused and fall back to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Parity mode codes as seen on i_Parity_Mode; 2'b11 behaves like PAR_NONE.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // True when the frame carries a parity bit.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity bit from the XOR of the data bits: even keeps it, odd inverts it.
  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    return data_xor ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO for queued transmit bytes. Head entry is visible
// combinationally on rdata_o; push while full and pop while empty are ignored.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ext.sv
// UART transmitter with a small input FIFO, optional even/odd parity and
// one or two stop bits. Frame settings are captured when a byte is popped.
//
// Handshake: a byte is accepted on every rising edge of i_Clock where
// i_Tx_Valid and o_Tx_Ready are both high; o_Tx_Ready is high whenever the
// FIFO has a free entry and does not depend on i_Tx_Valid. Offers made while
// o_Tx_Ready is low are dropped, and the offer need not be held afterwards.
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  localparam int FCNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 i_Clock,
  input  logic                 reset,
  input  logic                 i_Tx_Valid,
  output logic                 o_Tx_Ready,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Two_Stop,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done,
  output logic [FCNT_W-1:0]    o_Fifo_Count
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  // FIFO connections
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [FCNT_W-1:0]    fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Serializer state
  tx_state_e            state_q;
  logic [TMR_W-1:0]     tmr_q;       // cycles spent in the current bit
  logic [IDX_W-1:0]     idx_q;       // data bit being sent
  logic [DATA_BITS-1:0] shift_q;     // remaining data bits, LSB next
  logic                 par_en_q;    // frame carries a parity bit
  logic                 par_bit_q;   // parity bit value for the frame
  logic                 two_stop_q;  // frame ends with two stop bits
  logic                 stop2_q;     // currently in the second stop bit
  logic                 serial_q;
  logic                 active_q;
  logic                 done_q;

  // Derived per-cycle conditions
  logic                 bit_end_d;
  logic                 frame_end_d;
  logic                 load_d;

  assign fifo_push    = i_Tx_Valid && !fifo_full;
  assign fifo_pop     = load_d;
  assign o_Tx_Ready   = !fifo_full;
  assign o_Fifo_Count = fifo_count;
  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clock),
    .reset_i (reset),
    .push_i  (fifo_push),
    .wdata_i (i_Tx_Byte),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Bit-end, frame-end and pop decisions for the current cycle.
  always_comb begin
    bit_end_d   = (tmr_q == TMR_LAST);
    frame_end_d = (state_q == ST_STOP) && bit_end_d && (!two_stop_q || stop2_q);
    load_d      = !fifo_empty && ((state_q == ST_IDLE) || frame_end_d);
  end

  // Serializer FSM with bit timer and registered line/status outputs.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_d) begin
        // Pop the head byte and capture the frame settings in one edge,
        // either from IDLE or straight out of the last stop bit.
        state_q    <= ST_START;
        tmr_q      <= '0;
        idx_q      <= '0;
        stop2_q    <= 1'b0;
        shift_q    <= fifo_rdata;
        par_en_q   <= parity_enabled(i_Parity_Mode);
        par_bit_q  <= parity_bit(i_Parity_Mode, ^fifo_rdata);
        two_stop_q <= i_Two_Stop;
        serial_q   <= 1'b0;
        active_q   <= 1'b1;
        if (frame_end_d) begin
          done_q <= 1'b1;
        end
      end else begin
        if (state_q != ST_IDLE) begin
          tmr_q <= bit_end_d ? '0 : tmr_q + TMR_W'(1);
        end
        case (state_q)
          ST_IDLE: begin
            serial_q <= 1'b1;
            active_q <= 1'b0;
            tmr_q    <= '0;
          end
          ST_START: begin
            if (bit_end_d) begin
              state_q  <= ST_DATA;
              idx_q    <= '0;
              serial_q <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end
          ST_DATA: begin
            if (bit_end_d) begin
              if (idx_q == IDX_LAST) begin
                if (par_en_q) begin
                  state_q  <= ST_PARITY;
                  serial_q <= par_bit_q;
                end else begin
                  state_q  <= ST_STOP;
                  stop2_q  <= 1'b0;
                  serial_q <= 1'b1;
                end
              end else begin
                idx_q    <= idx_q + IDX_W'(1);
                serial_q <= shift_q[0];
                shift_q  <= shift_q >> 1;
              end
            end
          end
          ST_PARITY: begin
            if (bit_end_d) begin
              state_q  <= ST_STOP;
              stop2_q  <= 1'b0;
              serial_q <= 1'b1;
            end
          end
          ST_STOP: begin
            if (bit_end_d) begin
              if (two_stop_q && !stop2_q) begin
                stop2_q <= 1'b1;
              end else begin
                state_q  <= ST_IDLE;
                serial_q <= 1'b1;
                active_q <= 1'b0;
                done_q   <= 1'b1;
              end
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            idx_q    <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
